// File: rtl/sequenciador_pwm.sv
// rtl/sequenciador_pwm.sv - PWM profile sequencer driving pulso from a small profile table
// Optional SEQUENCIADOR_PWM_LOOP_EN replays the table endlessly instead of ending in CONCLUIDO.
module sequenciador_pwm #(
  parameter int NUM_PERFIS  = 4,
  parameter int LARGURA     = 8,
  parameter int LARGURA_REP = 8,
  localparam int IW         = $clog2(NUM_PERFIS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   escrever,
  input  logic [IW-1:0]          endereco,
  input  logic [LARGURA-1:0]     dado_periodo,
  input  logic [LARGURA-1:0]     dado_alto,
  input  logic [LARGURA_REP-1:0] dado_repeticoes,
  input  logic                   iniciar,
  input  logic                   parar,
  output logic                   pulso,
  output logic                   habilitar_contagem,
  output logic                   ocupado,
  output logic                   concluido,
  output logic [IW-1:0]          perfil_atual
);

  typedef enum logic [2:0] {OCIOSO, CARREGA, EXECUTA, PROXIMO, CONCLUIDO} estado_t;

  estado_t                estado_q, estado_d;
  logic [LARGURA-1:0]     tab_periodo_q [NUM_PERFIS];
  logic [LARGURA-1:0]     tab_alto_q    [NUM_PERFIS];
  logic [LARGURA_REP-1:0] tab_rep_q     [NUM_PERFIS];
  logic [LARGURA-1:0]     periodo_q, periodo_d, alto_q, alto_d, fase_q, fase_d;
  logic [LARGURA_REP-1:0] rep_total_q, rep_total_d, rep_q, rep_d;
  logic [IW-1:0]          indice_q, indice_d;
  logic                   pulso_q, pulso_d, habilitar_q, habilitar_d;
  logic                   ocupado_q, ocupado_d, concluido_q, concluido_d;
  logic                   fim_periodo, fim_perfil, ultimo;

  assign fim_periodo = (fase_q == periodo_q - LARGURA'(1));
  assign fim_perfil  = fim_periodo && (rep_q == rep_total_q - LARGURA_REP'(1));
  assign ultimo      = (indice_q == IW'(NUM_PERFIS - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q    <= OCIOSO;
      periodo_q   <= '0;
      alto_q      <= '0;
      rep_total_q <= '0;
      fase_q      <= '0;
      rep_q       <= '0;
      indice_q    <= '0;
      pulso_q     <= 1'b0;
      habilitar_q <= 1'b0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      for (int i = 0; i < NUM_PERFIS; i++) begin
        tab_periodo_q[i] <= '0;
        tab_alto_q[i]    <= '0;
        tab_rep_q[i]     <= '0;
      end
    end else begin
      estado_q    <= estado_d;
      periodo_q   <= periodo_d;
      alto_q      <= alto_d;
      rep_total_q <= rep_total_d;
      fase_q      <= fase_d;
      rep_q       <= rep_d;
      indice_q    <= indice_d;
      pulso_q     <= pulso_d;
      habilitar_q <= habilitar_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
      // The table is frozen while a sequence is running
      if (estado_q == OCIOSO && escrever) begin
        tab_periodo_q[endereco] <= dado_periodo;
        tab_alto_q[endereco]    <= dado_alto;
        tab_rep_q[endereco]     <= dado_repeticoes;
      end
    end
  end

  always_comb begin
    estado_d    = estado_q;
    indice_d    = indice_q;
    periodo_d   = periodo_q;
    alto_d      = alto_q;
    rep_total_d = rep_total_q;
    fase_d      = fase_q;
    rep_d       = rep_q;
    unique case (estado_q)
      OCIOSO: begin
        if (iniciar && !parar) begin
          estado_d = CARREGA;
          indice_d = '0;
        end
      end
      CARREGA: begin
        periodo_d   = tab_periodo_q[indice_q];
        alto_d      = tab_alto_q[indice_q];
        rep_total_d = tab_rep_q[indice_q];
        fase_d      = '0;
        rep_d       = '0;
        if (tab_periodo_q[indice_q] == '0 || tab_rep_q[indice_q] == '0) estado_d = PROXIMO;
        else estado_d = EXECUTA;
      end
      EXECUTA: begin
        if (fim_periodo) begin
          fase_d = '0;
          if (fim_perfil) estado_d = PROXIMO;
          else rep_d = rep_q + LARGURA_REP'(1);
        end else begin
          fase_d = fase_q + LARGURA'(1);
        end
      end
      PROXIMO: begin
        if (!ultimo) begin
          indice_d = indice_q + IW'(1);
          estado_d = CARREGA;
        end else begin
`ifdef SEQUENCIADOR_PWM_LOOP_EN
          indice_d = '0;
          estado_d = CARREGA;
`else
          estado_d = CONCLUIDO;
`endif
        end
      end
      CONCLUIDO: begin
        estado_d = OCIOSO;
        indice_d = '0;
      end
      default: estado_d = OCIOSO;
    endcase
    if (parar && estado_q != OCIOSO) begin
      estado_d = OCIOSO;
      indice_d = '0;
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe
  always_comb begin
    pulso_d     = (estado_d == EXECUTA) && (fase_d < alto_d);
    habilitar_d = (estado_d == EXECUTA);
    ocupado_d   = (estado_d != OCIOSO);
    concluido_d = (estado_d == CONCLUIDO);
  end

  assign pulso              = pulso_q;
  assign habilitar_contagem = habilitar_q;
  assign ocupado            = ocupado_q;
  assign concluido          = concluido_q;
  assign perfil_atual       = indice_q;

endmodule

// File: doc/sequenciador_pwm.md
# sequenciador_pwm

Profile sequencer that drives the PWM generation path. It holds a small table of waveform profiles (period, high time, repeat count). On a start request it plays the profiles in order on one `pulso` output, and asserts `habilitar_contagem` toward downstream oscillator instances while a profile is active. It sits between the control logic (start/stop/table writes) and the PWM output stage, and it owns all sequencing of that stage.

## Interface
- `NUM_PERFIS`, 4: number of table entries; must be a power of two, 2..16.
- `LARGURA`, 8: width of period and high-time fields, in clock cycles.
- `LARGURA_REP`, 8: width of the repeat-count field.
- `clock`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `escrever`  in  1  table write strobe; honoured only in OCIOSO.
- `endereco`  in  log2(NUM_PERFIS)  table entry written.
- `dado_periodo`  in  LARGURA  period P.
- `dado_alto`  in  LARGURA  high time H.
- `dado_repeticoes`  in  LARGURA_REP  repeat count R.
- `iniciar`  in  1  start request, level-sampled in OCIOSO.
- `parar`  in  1  abort; priority over `iniciar`.
- `pulso`  out  1  PWM waveform, registered.
- `habilitar_contagem`  out  1  high while in EXECUTA, registered.
- `ocupado`  out  1  high in every state except OCIOSO.
- `concluido`  out  1  one-cycle pulse when a sequence ends normally.
- `perfil_atual`  out  log2(NUM_PERFIS)  index of the profile being played.

## Operation
- Reset (`reset`=0 at an edge):
  - all table entries cleared to 0;
  - state goes to OCIOSO;
  - `pulso`, `habilitar_contagem`, `ocupado`, `concluido` and `perfil_atual` all go to 0.
- OCIOSO:
  - `escrever`=1 commits the three fields to `endereco` at that edge.
  - `iniciar`=1 and `parar`=0 → go to CARREGA with index 0.
  - `iniciar` and `escrever` in the same cycle: the write commits, and CARREGA reads the updated entry.
- CARREGA (1 cycle):
  - latches P/H/R of the current index into working registers;
  - clears the phase counter and the repeat counter;
  - `pulso`=0.
  - If P=0 or R=0, the profile is skipped: go to PROXIMO. Otherwise go to EXECUTA.
- EXECUTA:
  - `pulso`=1 while phase < H, else 0.
  - The phase counter runs 0..P-1 and then wraps to 0; each wrap increments the repeat counter.
  - After phase P-1 of repeat R-1, go to PROXIMO.
  - H ≥ P: `pulso` stays 1 for the whole profile. H=0: `pulso` stays 0.
- PROXIMO (1 cycle):
  - If index < NUM_PERFIS-1: increment the index and go to CARREGA.
  - Else: go to CONCLUIDO.
- CONCLUIDO (1 cycle): `concluido`=1, then go to OCIOSO.
- `parar`=1 in any non-OCIOSO state:
  - next edge goes to OCIOSO;
  - `pulso`, `habilitar_contagem` and `perfil_atual` go to 0;
  - no `concluido` is generated.
- `escrever` while `ocupado`=1 is ignored; the table is unchanged.
- Counters use LARGURA/LARGURA_REP bits with no overflow; the maximum profile length is 255×255 cycles at default widths.

## Timing
- Edge k samples `iniciar`=1:
  - after k: CARREGA, `ocupado`=1;
  - after k+1: EXECUTA, with `pulso`=1 if H>0 and `habilitar_contagem`=1.
- Each non-skipped profile occupies exactly P×R cycles in EXECUTA, plus 1 CARREGA cycle and 1 PROXIMO cycle.
- A skipped profile costs 2 cycles (CARREGA + PROXIMO), with `pulso`=0.
- Gaps between profiles:
  - `habilitar_contagem`=0 and `pulso`=0 during CARREGA/PROXIMO;
  - `perfil_atual` updates on entry to CARREGA.
- `concluido` is high for exactly the one cycle after the last PROXIMO; `ocupado` is still 1 in that cycle and falls with it.
- `parar` sampled at edge m: outputs are at reset values after m.

## Configuration
- `SEQUENCIADOR_PWM_LOOP_EN` defined:
  - PROXIMO after the last index wraps the index to 0 and goes to CARREGA;
  - the sequence repeats until `parar` or `reset`;
  - `concluido` is never asserted;
  - if every profile is skippable, the block cycles CARREGA/PROXIMO with `pulso`=0.
- Not defined: single pass, ending via CONCLUIDO as described above.

## Test plan
- Reset mid-EXECUTA with `pulso`=1 → after the next edge, all outputs are 0, state is OCIOSO, and reading back via a start shows profile 0 skipped (table cleared).
- Profile 0 = {P=4,H=1,R=3}, others have P=0; pulse `iniciar` → `pulso` pattern 1000 1000 1000 starting 2 edges after the start sample. Without the loop macro: `concluido` pulses after 12+2+6 cycles. With the loop macro: the pattern repeats.
- Profiles {P=3,H=3,R=1} and {P=2,H=0,R=2} → `pulso` 111, a 2-cycle gap, then 0000. `perfil_atual` steps 0→1, and `habilitar_contagem` is low in the gaps.
- `parar` asserted on the third EXECUTA cycle → `pulso`/`ocupado` are 0 next cycle and `concluido` never pulses. `iniciar` and `parar` together in OCIOSO → stays idle.
- `escrever` to entry 0 while `ocupado`=1 → the table is unchanged on the next run.
- `escrever` and `iniciar` in the same OCIOSO cycle → the new values are played.
